// File: rtl/or_sched_pkg.sv
// or_sched_pkg: shared state encoding and width helpers for the OR-gate scheduler
package or_sched_pkg;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_PULSE_A, S_PULSE_B, S_PULSE_CLK, S_RESP} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int g, input int o, input int b);
    int m;
    m = (g > o) ? g : o;
    m = (m > b) ? m : b;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first set request at or after the pointer, wrapping
module rr_arbiter
  import or_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_en && !o_any && i_req[(i + int'(i_ptr)) % NUM_REQ]) begin
        o_any = 1'b1;
        o_gnt[(i + int'(i_ptr)) % NUM_REQ] = 1'b1;
        o_idx = IW'((i + int'(i_ptr)) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/or_gate_scheduler.sv
// or_gate_scheduler: round-robin sequencer driving spaced a/b/clk pulses into one shared clocked-OR gate
module or_gate_scheduler
  import or_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 3,
  parameter int OUT_CYCLES   = 6,
  parameter int BEGIN_CYCLES = 8,
  localparam int IW = idx_w(NUM_REQ),
  localparam int CW = cnt_w(GAP_CYCLES, OUT_CYCLES, BEGIN_CYCLES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] op_a,
  input  logic [NUM_REQ-1:0] op_b,
  output logic [NUM_REQ-1:0] gnt,
  output logic               resp_valid,
  output logic [IW-1:0]      resp_id,
  output logic               resp_data,
  output logic               busy,
  output logic               gate_a,
  output logic               gate_b,
  output logic               gate_clk,
  input  logic               gate_out,
  output logic               err
);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt, w_lim;
  logic [IW-1:0] r_ptr, r_idx, w_idx;
  logic [NUM_REQ-1:0] w_win;
  logic w_any, w_done, r_b, r_ref, r_gout_q, r_gout_v;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req(req), .i_ptr(r_ptr), .i_en(r_state == S_IDLE),
    .o_gnt(w_win), .o_idx(w_idx), .o_any(w_any)
  );

  assign busy = r_state != S_IDLE;

  always_comb begin
    w_lim = (r_state == S_INIT) ? CW'(BEGIN_CYCLES - 1) :
            (r_state == S_PULSE_CLK) ? CW'(OUT_CYCLES - 1) : CW'(GAP_CYCLES - 1);
    w_done = r_cnt == w_lim;
    w_next = r_state;
    case (r_state)
      S_INIT:      if (w_done) w_next = S_IDLE;
      S_IDLE:      if (w_any) w_next = S_PULSE_A;
      S_PULSE_A:   if (w_done) w_next = S_PULSE_B;
      S_PULSE_B:   if (w_done) w_next = S_PULSE_CLK;
      S_PULSE_CLK: if (w_done) w_next = S_RESP;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_INIT;
    else r_state <= w_next;

  // Pulses are issued on the edge that enters each pulse state; r_gout_v masks the first compare after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_ptr      <= '0;
      r_idx      <= '0;
      r_b        <= 1'b0;
      r_ref      <= 1'b0;
      r_gout_q   <= 1'b0;
      r_gout_v   <= 1'b0;
      gnt        <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= 1'b0;
      gate_a     <= 1'b0;
      gate_b     <= 1'b0;
      gate_clk   <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_cnt      <= (w_next != r_state) ? '0 : (&r_cnt) ? r_cnt : r_cnt + 1'b1;
      gnt        <= w_win;
      resp_valid <= r_state == S_PULSE_CLK && w_done;
      r_gout_q   <= gate_out;
      r_gout_v   <= 1'b1;
      err        <= err | (r_gout_v && r_state != S_PULSE_CLK && gate_out != r_gout_q);
      if (w_any) begin
        r_idx  <= w_idx;
        r_b    <= op_b[w_idx];
        r_ptr  <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
        gate_a <= gate_a ^ op_a[w_idx];
      end
      if (r_state == S_PULSE_A && w_done) gate_b <= gate_b ^ r_b;
      if (r_state == S_PULSE_B && w_done) begin
        gate_clk <= ~gate_clk;
        r_ref    <= gate_out;
      end
      if (r_state == S_PULSE_CLK && w_done) begin
        resp_id   <= r_idx;
        resp_data <= gate_out ^ r_ref;
      end
    end
  end
endmodule

// File: tb/tb_or_gate_scheduler.sv
// tb_or_gate_scheduler: directed checks of grant order, pulse timing, results, err and reset
module tb_or_gate_scheduler;
  localparam int G = 3, O = 6, B = 8;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] req = '0, op_a = '0, op_b = '0, gnt;
  logic resp_valid, resp_data, busy, gate_a, gate_b, gate_clk, gate_out, err;
  logic [1:0] resp_id;
  logic gout = 1'b0, inj = 1'b0, flag = 1'b0, f;
  int checks = 0, failures = 0;

  assign gate_out = gout ^ inj;

  or_gate_scheduler #(.NUM_REQ(4), .GAP_CYCLES(G), .OUT_CYCLES(O), .BEGIN_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .gnt(gnt),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .busy(busy),
    .gate_a(gate_a), .gate_b(gate_b), .gate_clk(gate_clk), .gate_out(gate_out), .err(err)
  );

  always #5 clk = ~clk;

  // Gate model: any a/b pulse arms it; the clk pulse toggles out 1 ns later if armed
  always @(posedge rst) flag = 1'b0;
  always @(gate_a or gate_b) if (!rst) flag = 1'b1;
  always @(gate_clk) if (!rst) begin
    f = flag;
    flag = 1'b0;
    if (f) begin
      #1 gout = ~gout;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic observe(output logic [3:0] g, output int wg, na, nb, nc, ea, eb, ec, er,
                         output logic rd, output logic [1:0] rid);
    logic pa, pb, pc;
    pa = gate_a; pb = gate_b; pc = gate_clk;
    g = '0; wg = -1; na = 0; nb = 0; nc = 0; ea = -1; eb = -1; ec = -1; er = -1; rd = 1'b0; rid = '0;
    for (int t = 1; t <= 60 && er < 0; t++) begin
      tick;
      if (wg < 0 && gnt != 0) begin wg = t; g = gnt; end
      if (gate_a != pa) begin na++; ea = t - wg; pa = gate_a; end
      if (gate_b != pb) begin nb++; eb = t - wg; pb = gate_b; end
      if (gate_clk != pc) begin nc++; ec = t - wg; pc = gate_clk; end
      if (resp_valid) begin er = t - wg; rd = resp_data; rid = resp_id; end
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({gnt, resp_valid, resp_id, resp_data, busy, err, gate_a, gate_b, gate_clk} !== 13'b0000_0_00_0_1_0_000) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected %b",
               {gnt, resp_valid, resp_id, resp_data, busy, err, gate_a, gate_b, gate_clk}, 13'b0000_0_00_0_1_0_000);
    end
    tick; tick;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_first;
    logic [3:0] g; int wg, na, nb, nc, ea, eb, ec, er; logic rd; logic [1:0] rid;
    for (int k = 1; k <= B; k++) begin
      tick;
      if (k == 1) begin req = 4'b0001; op_a = 4'b0001; op_b = 4'b0000; end
      checks++;
      if (gnt !== 4'b0) begin failures++; $display("FAIL init_gnt cycle %0d: got %b expected 0000", k, gnt); end
    end
    observe(g, wg, na, nb, nc, ea, eb, ec, er, rd, rid);
    checks++; if (wg !== 1) begin failures++; $display("FAIL first_grant_wait: got %0d expected 1", wg); end
    checks++; if (g !== 4'b0001) begin failures++; $display("FAIL first_gnt: got %b expected 0001", g); end
    checks++; if ({na, nb, nc} !== {32'd1, 32'd0, 32'd1}) begin failures++; $display("FAIL first_pulse_counts: got a=%0d b=%0d clk=%0d expected 1 0 1", na, nb, nc); end
    checks++; if ({ea, ec} !== {32'd0, 32'(2*G)}) begin failures++; $display("FAIL first_pulse_edges: got a=%0d clk=%0d expected 0 %0d", ea, ec, 2*G); end
    checks++; if (er !== 2*G+O) begin failures++; $display("FAIL first_resp_edge: got %0d expected %0d", er, 2*G+O); end
    checks++; if ({rd, rid} !== 3'b1_00) begin failures++; $display("FAIL first_resp: got data=%b id=%0d expected 1 0", rd, rid); end
    req = '0;
    tick;
    checks++; if ({resp_valid, busy} !== 2'b00) begin failures++; $display("FAIL first_after: got valid=%b busy=%b expected 0 0", resp_valid, busy); end
  endtask

  task automatic test_zero;
    logic [3:0] g; int wg, na, nb, nc, ea, eb, ec, er; logic rd; logic [1:0] rid;
    req = 4'b0100; op_a = 4'b0000; op_b = 4'b0000;
    observe(g, wg, na, nb, nc, ea, eb, ec, er, rd, rid);
    checks++; if (g !== 4'b0100) begin failures++; $display("FAIL zero_gnt: got %b expected 0100", g); end
    checks++; if ({na, nb, nc} !== {32'd0, 32'd0, 32'd1}) begin failures++; $display("FAIL zero_pulse_counts: got a=%0d b=%0d clk=%0d expected 0 0 1", na, nb, nc); end
    checks++; if ({rd, rid, er} !== {1'b0, 2'd2, 32'(2*G+O)}) begin failures++; $display("FAIL zero_resp: got data=%b id=%0d edge=%0d expected 0 2 %0d", rd, rid, er, 2*G+O); end
    req = '0;
    tick;
  endtask

  task automatic test_both;
    logic [3:0] g; int wg, na, nb, nc, ea, eb, ec, er; logic rd; logic [1:0] rid;
    req = 4'b1000; op_a = 4'b1000; op_b = 4'b1000;
    observe(g, wg, na, nb, nc, ea, eb, ec, er, rd, rid);
    checks++; if (g !== 4'b1000) begin failures++; $display("FAIL both_gnt: got %b expected 1000", g); end
    checks++; if ({na, nb, nc} !== {32'd1, 32'd1, 32'd1}) begin failures++; $display("FAIL both_pulse_counts: got a=%0d b=%0d clk=%0d expected 1 1 1", na, nb, nc); end
    checks++; if ({eb - ea, ec - eb} !== {32'(G), 32'(G)}) begin failures++; $display("FAIL both_spacing: got %0d %0d expected %0d %0d", eb - ea, ec - eb, G, G); end
    checks++; if ({rd, rid} !== 3'b1_11) begin failures++; $display("FAIL both_resp: got data=%b id=%0d expected 1 3", rd, rid); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL both_err: got %b expected 0", err); end
    req = '0;
    tick;
  endtask

  task automatic test_back_to_back;
    logic [3:0] g; int wg, na, nb, nc, ea, eb, ec, er; logic rd; logic [1:0] rid;
    logic [3:0] exp_g;
    req = 4'b1111; op_a = 4'b0101; op_b = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      observe(g, wg, na, nb, nc, ea, eb, ec, er, rd, rid);
      checks++; if (g !== exp_g) begin failures++; $display("FAIL rr_gnt %0d: got %b expected %b", k, g, exp_g); end
      checks++; if (wg !== ((k == 0) ? 1 : 2)) begin failures++; $display("FAIL rr_spacing %0d: got %0d expected %0d", k, wg, (k == 0) ? 1 : 2); end
      checks++; if ({rid, rd} !== {2'(k % 4), op_a[k % 4]}) begin failures++; $display("FAIL rr_resp %0d: got id=%0d data=%b expected %0d %b", k, rid, rd, k % 4, op_a[k % 4]); end
    end
    req = '0;
    tick;
  endtask

  task automatic test_err;
    tick;
    checks++; if ({busy, err} !== 2'b00) begin failures++; $display("FAIL err_pre: got busy=%b err=%b expected 0 0", busy, err); end
    inj = 1'b1;
    tick;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set: got %b expected 1", err); end
    repeat (3) tick;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_reset_mid;
    bit seen;
    seen = 1'b0;
    req = 4'b0100; op_a = 4'b0100; op_b = 4'b0100;
    for (int t = 0; t < 20 && !seen; t++) begin
      tick;
      seen = gnt != 0;
    end
    checks++; if (!seen) begin failures++; $display("FAIL mid_grant: got none expected 0100"); end
    req = '0;
    repeat (4) tick;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({gnt, resp_valid, resp_id, resp_data, busy, err, gate_a, gate_b, gate_clk} !== 13'b0000_0_00_0_1_0_000) begin
      failures++;
      $display("FAIL mid_reset_outputs: got %b expected %b",
               {gnt, resp_valid, resp_id, resp_data, busy, err, gate_a, gate_b, gate_clk}, 13'b0000_0_00_0_1_0_000);
    end
    req = 4'b1010; op_a = 4'b0000; op_b = 4'b0000;
    tick; tick;
    @(negedge clk) rst = 1'b0;
    for (int k = 1; k <= B; k++) begin
      tick;
      checks++;
      if ({gnt, resp_valid} !== 5'b0) begin failures++; $display("FAIL mid_wait cycle %0d: got gnt=%b valid=%b expected 0000 0", k, gnt, resp_valid); end
    end
    tick;
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL mid_fresh_gnt: got %b expected 0010", gnt); end
    req = '0;
  endtask

  initial begin
    test_reset;
    test_first;
    test_zero;
    test_both;
    test_back_to_back;
    test_err;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
